// File: rtl/watch_ctrl.sv
// Button front end for WATCH: synchronise, debounce, encode presses into command
// strobes, and sequence the display mode with a tick-based timeout back to RUN.
//
// state     | meaning
// ----------+------------------------------------------
// RUN       | normal time display
// SET_HH    | setting hours (blinks, times out)
// SET_MM    | setting minutes (blinks, times out)
// ALM_HH    | setting alarm hours (blinks, times out)
// ALM_MM    | setting alarm minutes (blinks, times out)
// STOPWATCH | stopwatch display
module watch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_TICKS   = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [7:0] btn_n,
    output logic [3:0] flag,
    output logic       cmd_valid,
    output logic [3:0] state,
    output logic       blink
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]    IDLE_LAST = 8'(TIMEOUT_TICKS - 1);

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        SET_HH    = 3'd1,
        SET_MM    = 3'd2,
        ALM_HH    = 3'd3,
        ALM_MM    = 3'd4,
        STOPWATCH = 3'd5
    } mode_t;

    mode_t         mode_q, mode_d;
    logic [7:0]    s1, s2, prev, stable, stable_d;
    logic [CW-1:0] cnt;
    logic [7:0]    idle;
    logic [7:0]    new_press;
    logic          press;
    logic [2:0]    press_idx;
    logic          setting;
    logic          timeout;
    logic          mode_change;

    // One shared counter: any change on any button restarts the whole vector.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1       <= '0;
            s2       <= '0;
            prev     <= '0;
            cnt      <= '0;
            stable   <= '0;
            stable_d <= '0;
        end else begin
            s1       <= ~btn_n;
            s2       <= s1;
            prev     <= s2;
            stable_d <= stable;
            if (s2 != prev)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
            if (cnt == CNT_MAX && s2 == prev)
                stable <= s2;
        end
    end

    // Lowest index wins; simultaneous extra presses are dropped.
    always_comb begin
        new_press = stable & ~stable_d;
        press     = |new_press;
        press_idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (new_press[i])
                press_idx = 3'(i);
        end
    end

    assign setting = (mode_q == SET_HH) || (mode_q == SET_MM) ||
                     (mode_q == ALM_HH) || (mode_q == ALM_MM);
    assign timeout = setting && tick && (idle == IDLE_LAST);

    always_comb begin
        mode_d = mode_q;
        if (press) begin
            if (press_idx == 3'd0)
                mode_d = (mode_q == STOPWATCH) ? RUN : mode_t'(mode_q + 3'd1);
            else if (press_idx == 3'd7)
                mode_d = RUN;
        end else if (timeout) begin
            mode_d = RUN;
        end
    end

    assign mode_change = (mode_d != mode_q);

    always_ff @(posedge clk) begin
        if (!rst_n)
            mode_q <= RUN;
        else
            mode_q <= mode_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag      <= '0;
            cmd_valid <= 1'b0;
            idle      <= '0;
            blink     <= 1'b0;
        end else begin
            cmd_valid <= press;
            if (press)
                flag <= {1'b0, press_idx};
            if (press || mode_change)
                idle <= '0;
            else if (setting && tick)
                idle <= idle + 8'd1;
            if (mode_change || !setting)
                blink <= 1'b0;
            else if (tick)
                blink <= ~blink;
        end
    end

    assign state = {1'b0, mode_q};

endmodule
